// File: rtl/controle_posicionamento_embarcacao_pkg.sv
// Shared types and helpers for interactive ship placement.
// Board geometry, FSM states, anchor type and cell packing.
package controle_posicionamento_embarcacao_pkg;

  localparam int TAM_GRADE   = 10;
  localparam int MAX_CELULAS = 8;
  localparam int NCEL        = TAM_GRADE * TAM_GRADE;
  localparam int VW          = 8 * MAX_CELULAS;

  localparam logic [7:0] CELULA_NULA = 8'hFF;
  localparam logic [5:0] GRADE6      = 6'(TAM_GRADE);
  localparam logic [6:0] GRADE7      = 7'(TAM_GRADE);
  localparam logic [3:0] MAXC4       = 4'(MAX_CELULAS);

  typedef enum logic [1:0] {
    OCIOSO,
    EDITANDO,
    VERIFICANDO,
    CONCLUIDO
  } estado_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       vert;
  } ancora_t;

  typedef struct packed {
    logic confirmar;
    logic rotacionar;
    logic downArrow;
    logic upArrow;
    logic rightArrow;
    logic leftArrow;
    logic inicio;
  } chaves_t;

  // Wide sums so that a step below zero (31) or past 15 is still rejected.
  function automatic logic cabe(
    logic [4:0] x,
    logic [4:0] y,
    logic       vert,
    logic [3:0] tam
  );
    logic [5:0] fim;
    logic [4:0] outro;
    fim   = (vert ? {1'b0, y} : {1'b0, x})
          + {2'b00, tam} - 6'd1;
    outro = vert ? x : y;
    return (fim < GRADE6) && ({1'b0, outro} < GRADE6);
  endfunction

  function automatic logic [VW-1:0] empacota(
    ancora_t    a,
    logic [3:0] tam
  );
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < MAX_CELULAS; k++) begin
      if (4'(k) < tam)
        v[8*k +: 8] = a.vert ? {a.y + 4'(k), a.x}
                             : {a.y, a.x + 4'(k)};
      else
        v[8*k +: 8] = CELULA_NULA;
    end
    return v;
  endfunction

  function automatic logic [6:0] indice(
    logic [3:0] x,
    logic [3:0] y
  );
    return {3'b000, y} * GRADE7 + {3'b000, x};
  endfunction

endpackage

// File: rtl/controle_posicionamento_embarcacao_if.sv
// Switch, occupancy and preview signals of the placement block.
// master drives switches/occupancy, slave is the controller.
interface controle_posicionamento_embarcacao_if;
  import controle_posicionamento_embarcacao_pkg::*;

  logic            inicio;
  logic [3:0]      tamanho;
  logic            leftArrow;
  logic            rightArrow;
  logic            upArrow;
  logic            downArrow;
  logic            rotacionar;
  logic            confirmar;
  logic [NCEL-1:0] mapaOcupado;
  logic [VW-1:0]   posicoesEmbarcacao;
  logic            exibir;
  logic            concluido;
  logic            erro;

  modport master (
    output inicio, tamanho,
    output leftArrow, rightArrow,
    output upArrow, downArrow,
    output rotacionar, confirmar,
    output mapaOcupado,
    input  posicoesEmbarcacao,
    input  exibir, concluido, erro
  );

  modport slave (
    input  inicio, tamanho,
    input  leftArrow, rightArrow,
    input  upArrow, downArrow,
    input  rotacionar, confirmar,
    input  mapaOcupado,
    output posicoesEmbarcacao,
    output exibir, concluido, erro
  );

endinterface

// File: rtl/controle_posicionamento_embarcacao_detector_borda.sv
// N-bit registered rising-edge detector for level switches.
// A switch held high produces exactly one edge.
module controle_posicionamento_embarcacao_detector_borda #(
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] i_nivel,
  output logic [N-1:0] o_borda
);

  logic [N-1:0] r_ant;

  always_ff @(posedge clock) begin
    if (reset) r_ant <= '0;
    else       r_ant <= i_nivel;
  end

  assign o_borda = i_nivel & ~r_ant;

endmodule

// File: rtl/controle_posicionamento_embarcacao.sv
// Interactive placement of one ship: clamped moves/rotation,
// serial collision check against the board, then commit.
module controle_posicionamento_embarcacao
  import controle_posicionamento_embarcacao_pkg::*;
(
  input logic clock,
  input logic reset,
  controle_posicionamento_embarcacao_if.slave bus
);

  chaves_t       w_nivel;
  chaves_t       w_borda;
  estado_t       r_estado, w_estado_n;
  ancora_t       r_anc, w_anc_n;
  logic [3:0]    r_tam, w_tam_n;
  logic [2:0]    r_k, w_k_n;
  logic          r_erro, w_erro_n;
  logic [VW-1:0] r_vec;

  logic [3:0] w_setas;
  logic       w_uma_seta;
  logic [4:0] w_cx, w_cy;
  logic [3:0] w_celx, w_cely;
  logic       w_ocupado;
  logic       w_tam_ok;

  assign w_nivel = {bus.confirmar, bus.rotacionar,
                    bus.downArrow, bus.upArrow,
                    bus.rightArrow, bus.leftArrow,
                    bus.inicio};

  controle_posicionamento_embarcacao_detector_borda #(
    .N(7)
  ) u_borda (
    .clock   (clock),
    .reset   (reset),
    .i_nivel (w_nivel),
    .o_borda (w_borda)
  );

  assign w_setas = {w_borda.upArrow, w_borda.downArrow,
                    w_borda.leftArrow, w_borda.rightArrow};
  assign w_uma_seta = (w_setas != 4'd0) &&
                      ((w_setas & (w_setas - 4'd1)) == 4'd0);

  assign w_cx = {1'b0, r_anc.x}
              + {4'd0, w_borda.rightArrow}
              - {4'd0, w_borda.leftArrow};
  assign w_cy = {1'b0, r_anc.y}
              + {4'd0, w_borda.upArrow}
              - {4'd0, w_borda.downArrow};

  assign w_celx = r_anc.vert ? r_anc.x : r_anc.x + {1'b0, r_k};
  assign w_cely = r_anc.vert ? r_anc.y + {1'b0, r_k} : r_anc.y;
  assign w_ocupado = bus.mapaOcupado[indice(w_celx, w_cely)];

  assign w_tam_ok = (bus.tamanho != 4'd0) &&
                    (bus.tamanho <= MAXC4);

  always_comb begin
    w_estado_n = r_estado;
    w_anc_n    = r_anc;
    w_tam_n    = r_tam;
    w_k_n      = r_k;
    w_erro_n   = 1'b0;
    unique case (r_estado)
      OCIOSO: begin
        if (w_borda.inicio) begin
          if (w_tam_ok) begin
            w_estado_n = EDITANDO;
            w_anc_n    = '0;
            w_tam_n    = bus.tamanho;
          end else begin
            w_erro_n = 1'b1;
          end
        end
      end
      EDITANDO: begin
        if (w_borda.confirmar) begin
          w_estado_n = VERIFICANDO;
          w_k_n      = 3'd0;
        end else if (w_uma_seta) begin
          if (cabe(w_cx, w_cy, r_anc.vert, r_tam)) begin
            w_anc_n.x = w_cx[3:0];
            w_anc_n.y = w_cy[3:0];
          end
        end else if (w_setas == 4'd0 && w_borda.rotacionar) begin
          if (cabe({1'b0, r_anc.x}, {1'b0, r_anc.y},
                   ~r_anc.vert, r_tam))
            w_anc_n.vert = ~r_anc.vert;
        end
      end
      VERIFICANDO: begin
        if (w_ocupado) begin
          w_estado_n = EDITANDO;
          w_erro_n   = 1'b1;
        end else if ({1'b0, r_k} == r_tam - 4'd1) begin
          w_estado_n = CONCLUIDO;
        end else begin
          w_k_n = r_k + 3'd1;
        end
      end
      CONCLUIDO: w_estado_n = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_anc    <= '0;
      r_tam    <= 4'd0;
      r_k      <= 3'd0;
      r_erro   <= 1'b0;
      r_vec    <= '1;
    end else begin
      r_estado <= w_estado_n;
      r_anc    <= w_anc_n;
      r_tam    <= w_tam_n;
      r_k      <= w_k_n;
      r_erro   <= w_erro_n;
      // Idle keeps showing the last committed ship.
      if (w_estado_n != OCIOSO)
        r_vec <= empacota(w_anc_n, w_tam_n);
    end
  end

  assign bus.posicoesEmbarcacao = r_vec;
  assign bus.exibir    = (r_estado == EDITANDO) ||
                         (r_estado == VERIFICANDO);
  assign bus.concluido = (r_estado == CONCLUIDO);
  assign bus.erro      = r_erro;

endmodule

// File: tb/tb_controle_posicionamento_embarcacao.sv
// Bench for the ship placement controller: directed table,
// corner sequences and random stimulus against a cell-list model.
module tb_controle_posicionamento_embarcacao;

  logic clock = 1'b0;
  logic reset;

  controle_posicionamento_embarcacao_if bus();

  controle_posicionamento_embarcacao dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       ini;
    bit [3:0] tam;
    bit       l, r, u, d, rot, conf;
  } in_t;

  typedef struct {
    in_t         s;
    logic [63:0] vec;
    bit          ex, co, er;
  } vet_t;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_mode, m_x, m_y, m_len, m_k;
  bit          m_v, m_err;
  logic [63:0] m_vec;
  in_t         m_prev;
  logic [99:0] mapa;

  function automatic in_t mk(bit ini, int tam, bit l, bit r,
                             bit u, bit d, bit rot, bit conf);
    in_t s;
    s.ini = ini; s.tam = 4'(tam);
    s.l = l; s.r = r; s.u = u; s.d = d;
    s.rot = rot; s.conf = conf;
    return s;
  endfunction

  function automatic bit cabe_m(int x, int y, bit v, int len);
    for (int i = 0; i < len; i++) begin
      int cx, cy;
      cx = v ? x : x + i;
      cy = v ? y + i : y;
      if (cx < 0 || cx > 9 || cy < 0 || cy > 9) return 0;
    end
    return 1;
  endfunction

  function automatic logic [63:0] pack_m(int x, int y, bit v, int len);
    logic [63:0] p;
    p = {64{1'b1}};
    for (int i = 0; i < len; i++) begin
      int cx, cy;
      cx = v ? x : x + i;
      cy = v ? y + i : y;
      p[8*i +: 8] = {4'(cy), 4'(cx)};
    end
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_v = 0;
    m_len = 0; m_k = 0; m_err = 0;
    m_vec = {64{1'b1}};
    m_prev = mk(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model(in_t s);
    bit ei, el, er, eu, ed, erot, ec;
    int na, nx, ny, cx, cy;
    ei = s.ini && !m_prev.ini;
    el = s.l && !m_prev.l;
    er = s.r && !m_prev.r;
    eu = s.u && !m_prev.u;
    ed = s.d && !m_prev.d;
    erot = s.rot && !m_prev.rot;
    ec = s.conf && !m_prev.conf;
    m_err = 0;
    case (m_mode)
      0: if (ei) begin
        if (s.tam >= 1 && s.tam <= 8) begin
          m_mode = 1; m_x = 0; m_y = 0; m_v = 0;
          m_len = int'(s.tam);
        end else m_err = 1;
      end
      1: begin
        na = int'(el) + int'(er) + int'(eu) + int'(ed);
        if (ec) begin
          m_mode = 2; m_k = 0;
        end else if (na == 1) begin
          nx = m_x - int'(el) + int'(er);
          ny = m_y + int'(eu) - int'(ed);
          if (cabe_m(nx, ny, m_v, m_len)) begin
            m_x = nx; m_y = ny;
          end
        end else if (na == 0 && erot) begin
          if (cabe_m(m_x, m_y, !m_v, m_len)) m_v = !m_v;
        end
      end
      2: begin
        cx = m_v ? m_x : m_x + m_k;
        cy = m_v ? m_y + m_k : m_y;
        if (mapa[cy*10 + cx]) begin
          m_mode = 1; m_err = 1;
        end else if (m_k == m_len - 1) m_mode = 3;
        else m_k++;
      end
      default: m_mode = 0;
    endcase
    if (m_mode != 0) m_vec = pack_m(m_x, m_y, m_v, m_len);
    m_prev = s;
  endtask

  task automatic drive(in_t s);
    bus.inicio     = s.ini;
    bus.tamanho    = s.tam;
    bus.leftArrow  = s.l;
    bus.rightArrow = s.r;
    bus.upArrow    = s.u;
    bus.downArrow  = s.d;
    bus.rotacionar = s.rot;
    bus.confirmar  = s.conf;
    bus.mapaOcupado = mapa;
  endtask

  task automatic check(string nome, logic [63:0] ev,
                       bit ex, bit co, bit er);
    n_tests++;
    if (bus.posicoesEmbarcacao !== ev || bus.exibir !== ex ||
        bus.concluido !== co || bus.erro !== er) begin
      n_fail++;
      $display("FAIL %s: got vec=%h ex=%b co=%b er=%b, expected vec=%h ex=%b co=%b er=%b",
               nome, bus.posicoesEmbarcacao, bus.exibir,
               bus.concluido, bus.erro, ev, ex, co, er);
    end
  endtask

  task automatic check_bit(string nome, logic got, logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nome, got, exp);
    end
  endtask

  task automatic check_vec(string nome, logic [63:0] exp);
    n_tests++;
    if (bus.posicoesEmbarcacao !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nome,
               bus.posicoesEmbarcacao, exp);
    end
  endtask

  task automatic step(in_t s, string nome = "step");
    drive(s);
    model(s);
    @(posedge clock);
    #1;
    check(nome, m_vec, m_mode == 1 || m_mode == 2,
          m_mode == 3, m_err);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check("reset", {64{1'b1}}, 0, 0, 0);
  endtask

  in_t  Z;
  vet_t tab[$];
  in_t  cur;

  initial begin
    Z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    mapa = '0;
    drive(Z);
    reset = 1'b1;
    @(posedge clock);
    #1;
    do_reset(2);

    tab.push_back('{mk(1,3,0,0,0,0,0,0), 64'hFFFF_FFFF_FF02_0100, 1, 0, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF02_0100, 1, 0, 0});
    tab.push_back('{mk(0,0,0,0,0,0,1,0), 64'hFFFF_FFFF_FF20_1000, 1, 0, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF20_1000, 1, 0, 0});
    tab.push_back('{mk(0,0,0,0,0,0,1,0), 64'hFFFF_FFFF_FF02_0100, 1, 0, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF02_0100, 1, 0, 0});
    tab.push_back('{mk(0,0,0,1,0,0,0,0), 64'hFFFF_FFFF_FF03_0201, 1, 0, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF03_0201, 1, 0, 0});
    tab.push_back('{mk(0,0,1,1,0,0,0,0), 64'hFFFF_FFFF_FF03_0201, 1, 0, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF03_0201, 1, 0, 0});
    tab.push_back('{mk(0,0,0,0,0,0,0,1), 64'hFFFF_FFFF_FF03_0201, 1, 0, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF03_0201, 1, 0, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF03_0201, 1, 0, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF03_0201, 0, 1, 0});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF03_0201, 0, 0, 0});
    tab.push_back('{mk(1,0,0,0,0,0,0,0), 64'hFFFF_FFFF_FF03_0201, 0, 0, 1});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF03_0201, 0, 0, 0});
    tab.push_back('{mk(1,9,0,0,0,0,0,0), 64'hFFFF_FFFF_FF03_0201, 0, 0, 1});
    tab.push_back('{Z,                   64'hFFFF_FFFF_FF03_0201, 0, 0, 0});
    tab.push_back('{mk(1,8,0,0,0,0,0,0), 64'h0706_0504_0302_0100, 1, 0, 0});

    foreach (tab[i]) begin
      drive(tab[i].s);
      model(tab[i].s);
      @(posedge clock);
      #1;
      check($sformatf("tab%0d", i), tab[i].vec,
            tab[i].ex, tab[i].co, tab[i].er);
    end

    // X clamp and simultaneous arrows
    do_reset(2);
    step(mk(1,3,0,0,0,0,0,0)); step(Z);
    repeat (9) begin
      step(mk(0,0,0,1,0,0,0,0)); step(Z);
    end
    check_vec("clamp_x", 64'hFFFF_FFFF_FF09_0807);
    step(mk(0,0,1,1,0,0,0,0)); step(Z);
    check_vec("dual_arrow", 64'hFFFF_FFFF_FF09_0807);

    // Y clamp while vertical and rotation limits
    do_reset(2);
    step(mk(1,3,0,0,0,0,0,0)); step(Z);
    step(mk(0,0,0,0,0,0,1,0)); step(Z);
    check_vec("rot_v", 64'hFFFF_FFFF_FF20_1000);
    repeat (8) begin
      step(mk(0,0,0,0,1,0,0,0)); step(Z);
    end
    check_vec("clamp_y", 64'hFFFF_FFFF_FF90_8070);
    step(mk(0,0,0,0,0,0,1,0)); step(Z);
    check_vec("rot_ok", 64'hFFFF_FFFF_FF72_7170);
    step(mk(0,0,0,0,0,0,1,0)); step(Z);
    repeat (8) begin
      step(mk(0,0,0,1,0,0,0,0)); step(Z);
    end
    step(mk(0,0,0,0,0,0,1,0)); step(Z);
    check_vec("rot_reject", 64'hFFFF_FFFF_FF98_8878);

    // collision, retry one row up, commit at t+4
    do_reset(2);
    mapa = '0;
    mapa[12] = 1'b1;
    step(mk(1,3,0,0,0,0,0,0)); step(Z);
    step(mk(0,0,0,0,1,0,0,0)); step(Z);
    step(mk(0,0,0,0,0,0,0,1));
    step(Z); step(Z);
    check_bit("col_no_erro_yet", bus.erro, 1'b0);
    step(Z);
    check_bit("col_erro", bus.erro, 1'b1);
    check_bit("col_exibir", bus.exibir, 1'b1);
    check_bit("col_no_conc", bus.concluido, 1'b0);
    step(mk(0,0,0,0,1,0,0,0)); step(Z);
    step(mk(0,0,0,0,0,0,0,1));
    step(Z); step(Z);
    check_bit("conc_not_early", bus.concluido, 1'b0);
    step(Z);
    check_bit("conc_t4", bus.concluido, 1'b1);
    check_vec("conc_vec", 64'hFFFF_FFFF_FF22_2120);
    step(Z);
    check_bit("conc_pulse", bus.concluido, 1'b0);

    // reset while checking
    mapa = '0;
    step(mk(1,4,0,0,0,0,0,0)); step(Z);
    step(mk(0,0,0,0,0,0,0,1)); step(Z);
    do_reset(1);
    repeat (6) step(Z);

    // random stimulus against the model
    cur = Z;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1);
        cur = Z;
      end else begin
        if (m_mode == 0 && $urandom_range(0, 3) == 0)
          for (int b = 0; b < 100; b++)
            mapa[b] = ($urandom_range(0, 9) == 0);
        cur.ini  ^= ($urandom_range(0, 7) == 0);
        cur.l    ^= ($urandom_range(0, 4) == 0);
        cur.r    ^= ($urandom_range(0, 4) == 0);
        cur.u    ^= ($urandom_range(0, 4) == 0);
        cur.d    ^= ($urandom_range(0, 4) == 0);
        cur.rot  ^= ($urandom_range(0, 5) == 0);
        cur.conf ^= ($urandom_range(0, 11) == 0);
        cur.tam  = 4'($urandom_range(0, 9));
        step(cur, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
